pulse_width_checker: RTL and testbench
======================================

Name: pulse_width_checker

Overview:
- Receive-side companion to the one-shot pulse generator.
- Samples a synchronous single-bit pulse line and measures each high pulse in clock cycles.
- Reports each measured width, flags widths that differ from the expected length, and flags over-long pulses (stuck-high line).
- Keeps saturating pass/error tallies for status readback and self-checking benches.

Parameters:
p_EXPECTED_LENGTH, 5, nominal pulse width in cycles; sets o_match.
p_MAX_LENGTH, 20, longest legal pulse; a longer pulse raises a timeout. Legal range 1 .. 2^p_CNT_WIDTH-1.
p_CNT_WIDTH, 16, width of the width counter and both tally counters.

Ports:
i_clk  in  1  system clock, rising edge.
i_rst  in  1  synchronous reset, active-high.
i_pulse  in  1  pulse line under test, already synchronous to i_clk.
i_clear  in  1  synchronous clear of both tally counters.
o_valid  out  1  one-cycle strobe: pulse measured; o_width and o_match are meaningful.
o_width  out  p_CNT_WIDTH  high time of the last measured pulse in cycles; held until the next o_valid.
o_match  out  1  last pulse width == p_EXPECTED_LENGTH; held like o_width.
o_timeout  out  1  one-cycle strobe: pulse exceeded p_MAX_LENGTH.
o_pass_count  out  p_CNT_WIDTH  number of matching pulses, saturating.
o_err_count  out  p_CNT_WIDTH  number of mismatches plus timeouts, saturating.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_valid, o_match, o_timeout = 0.
  - o_width, o_pass_count, o_err_count = 0.
  - Internal count = 0; state = S_WAIT_LOW.
- Reset has priority over every other input, including mid-measurement. A pulse in progress at reset is discarded and produces no strobe.
- State machine:
  - S_WAIT_LOW: i_pulse==0 -> S_IDLE. Otherwise stay. This prevents measuring a partial pulse after reset or after a timeout.
  - S_IDLE: i_pulse==1 -> S_MEASURE, count<=1.
  - S_MEASURE, i_pulse==1, count<p_MAX_LENGTH: count<=count+1.
  - S_MEASURE, i_pulse==1, count==p_MAX_LENGTH (pulse is now longer than max): o_timeout<=1 for one cycle; o_err_count increments; o_width and o_match unchanged; -> S_WAIT_LOW.
  - S_MEASURE, i_pulse==0 (falling edge): o_valid<=1 for one cycle; o_width<=count; o_match<=(count==p_EXPECTED_LENGTH); pass or err tally increments; -> S_IDLE.
- Width definition: N = number of consecutive rising edges at which i_pulse is sampled 1.
- Latency: o_valid is high in the cycle after the edge that first samples i_pulse==0.
- Back-to-back pulses: the minimum low gap is 1 sample.
  - The falling-edge cycle moves to S_IDLE. The next high sample starts a new measurement.
  - A one-cycle gap is therefore measured correctly.
- A pulse of exactly p_MAX_LENGTH cycles is legal and yields o_valid, not o_timeout.
- Tally counters saturate at 2^p_CNT_WIDTH-1 and never wrap.
- i_clear zeroes both tallies on the next edge.
- i_clear coinciding with an increment: clear wins and the counter reads 0.
- i_clear does not affect the state machine, o_width or o_match.
- o_valid and o_timeout are never high in the same cycle.

Test Plan:
1. After reset and 3 low cycles, drive i_pulse high for 5 cycles then low -> one o_valid strobe; o_width=5, o_match=1, o_pass_count=1, o_err_count=0.
2. Drive i_pulse high for 3 cycles (generator stopped early) -> o_valid; o_width=3, o_match=0, o_err_count=1, o_pass_count unchanged.
3. Hold i_pulse high for 25 cycles:
   - o_timeout strobes once, on the cycle after the 21st high sample; no o_valid on the fall; o_err_count+1.
   - A following 5-cycle pulse measures width=5, match=1.
4. Assert i_rst with i_pulse high; release it while i_pulse stays high for 4 more cycles, then low:
   - No o_valid, no o_timeout, tallies stay 0.
   - A subsequent 5-cycle pulse is measured normally.
5. Pulses of 1, 1 and 20 cycles, each separated by a 1-cycle gap:
   - Three o_valid strobes with widths 1, 1, 20; err_count=3; no timeout.
   - Then assert i_rst on the 3rd cycle of a 5-cycle pulse: no strobe and all outputs read 0.
6. Assert i_clear on the same cycle as a matching pulse's o_valid update -> o_pass_count=0 afterwards; o_width=5 retained.

Source files
------------

// File: rtl/pulse_width_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pulse_width_checker
// Description : Measures the high time of each pulse on a synchronous line,
//               flags width mismatches and over-long (stuck-high) pulses, and
//               keeps saturating pass/error tallies.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pulse_width_checker #(
  parameter int p_EXPECTED_LENGTH = 5,
  parameter int p_MAX_LENGTH      = 20,
  parameter int p_CNT_WIDTH       = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pulse,
  input  logic                   i_clear,
  output logic                   o_valid,
  output logic [p_CNT_WIDTH-1:0] o_width,
  output logic                   o_match,
  output logic                   o_timeout,
  output logic [p_CNT_WIDTH-1:0] o_pass_count,
  output logic [p_CNT_WIDTH-1:0] o_err_count
);

  localparam logic [p_CNT_WIDTH-1:0] EXP_LEN   = p_CNT_WIDTH'(p_EXPECTED_LENGTH);
  localparam logic [p_CNT_WIDTH-1:0] MAX_LEN   = p_CNT_WIDTH'(p_MAX_LENGTH);
  localparam logic [p_CNT_WIDTH-1:0] ONE       = p_CNT_WIDTH'(1);
  localparam logic [p_CNT_WIDTH-1:0] TALLY_MAX = '1;

  // S_WAIT_LOW guards against measuring a partial pulse after reset or timeout.
  typedef enum logic [1:0] {
    S_WAIT_LOW = 2'd0,
    S_IDLE     = 2'd1,
    S_MEASURE  = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_d;
  logic [p_CNT_WIDTH-1:0]   count;
  logic [p_CNT_WIDTH-1:0]   count_d;
  logic                     valid;
  logic                     valid_d;
  logic [p_CNT_WIDTH-1:0]   width;
  logic [p_CNT_WIDTH-1:0]   width_d;
  logic                     match;
  logic                     match_d;
  logic                     timeout;
  logic                     timeout_d;
  logic                     pass_inc;
  logic                     err_inc;
  logic [p_CNT_WIDTH-1:0]   pass_count;
  logic [p_CNT_WIDTH-1:0]   err_count;

  // State register; reset drops any pulse in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_WAIT_LOW;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, width counter and result decode for the measurement FSM.
  always_comb begin
    state_d   = state;
    count_d   = count;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    width_d   = width;
    match_d   = match;
    pass_inc  = 1'b0;
    err_inc   = 1'b0;
    case (state)
      S_WAIT_LOW: begin
        if (!i_pulse) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (i_pulse) begin
          state_d = S_MEASURE;
          count_d = ONE;
        end
      end
      S_MEASURE: begin
        if (i_pulse) begin
          if (count == MAX_LEN) begin
            // One sample beyond the legal maximum: report and re-arm on low.
            timeout_d = 1'b1;
            err_inc   = 1'b1;
            state_d   = S_WAIT_LOW;
          end else begin
            count_d = count + ONE;
          end
        end else begin
          valid_d = 1'b1;
          width_d = count;
          match_d = (count == EXP_LEN);
          if (count == EXP_LEN) begin
            pass_inc = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_WAIT_LOW;
      end
    endcase
  end

  // Registered counter and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count   <= '0;
      valid   <= 1'b0;
      width   <= '0;
      match   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      count   <= count_d;
      valid   <= valid_d;
      width   <= width_d;
      match   <= match_d;
      timeout <= timeout_d;
    end
  end

  // Saturating tallies; clear takes priority over a coincident increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      pass_count <= '0;
      err_count  <= '0;
    end else begin
      if (pass_inc && (pass_count != TALLY_MAX)) begin
        pass_count <= pass_count + ONE;
      end
      if (err_inc && (err_count != TALLY_MAX)) begin
        err_count <= err_count + ONE;
      end
    end
  end

  assign o_valid      = valid;
  assign o_width      = width;
  assign o_match      = match;
  assign o_timeout    = timeout;
  assign o_pass_count = pass_count;
  assign o_err_count  = err_count;

endmodule
`default_nettype wire

// File: tb/tb_pulse_width_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_pulse_width_checker
// Description : Self-checking bench for pulse_width_checker: vector table,
//               directed corner sequences, randomized run against a
//               run-length reference model, and tally saturation on a
//               narrow-counter instance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pulse_width_checker;

  localparam int EXP_LEN = 5;
  localparam int MAX_LEN = 20;
  localparam int CW      = 16;
  localparam int TALLY_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse = 1'b0;
  logic          clear = 1'b0;
  logic          valid;
  logic [CW-1:0] width;
  logic          match;
  logic          timeout;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] err_count;

  // Narrow-counter instance used only to reach tally saturation quickly.
  logic          pulse_s = 1'b0;
  logic          clear_s = 1'b0;
  logic          valid_s;
  logic [2:0]    width_s;
  logic          match_s;
  logic          timeout_s;
  logic [2:0]    pass_s;
  logic [2:0]    err_s;

  pulse_width_checker #(
    .p_EXPECTED_LENGTH(EXP_LEN), .p_MAX_LENGTH(MAX_LEN), .p_CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_clear(clear),
    .o_valid(valid), .o_width(width), .o_match(match), .o_timeout(timeout),
    .o_pass_count(pass_count), .o_err_count(err_count)
  );

  pulse_width_checker #(
    .p_EXPECTED_LENGTH(1), .p_MAX_LENGTH(3), .p_CNT_WIDTH(3)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_pulse(pulse_s), .i_clear(clear_s),
    .o_valid(valid_s), .o_width(width_s), .o_match(match_s), .o_timeout(timeout_s),
    .o_pass_count(pass_s), .o_err_count(err_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: run length of high samples, plus whether the line has
  // been seen low since reset/timeout (only then is a pulse measurable).
  int m_run = 0;
  bit m_armed = 1'b0;
  int m_valid = 0, m_width = 0, m_match = 0, m_timeout = 0, m_pass = 0, m_err = 0;
  int n_valid = 0, n_timeout = 0;

  typedef struct {
    logic p;
    logic c;
    int   v;
    int   w;
    int   m;
    int   t;
    int   pc;
    int   ec;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_outs(input string tag, input int v, input int w, input int m,
                          input int t, input int pc, input int ec);
    chk({tag, "_valid"},   32'(valid),      v);
    chk({tag, "_width"},   32'(width),      w);
    chk({tag, "_match"},   32'(match),      m);
    chk({tag, "_timeout"}, 32'(timeout),    t);
    chk({tag, "_pass"},    32'(pass_count), pc);
    chk({tag, "_err"},     32'(err_count),  ec);
  endtask

  task automatic model_step(input logic p, input logic c, input logic r);
    m_valid   = 0;
    m_timeout = 0;
    if (r) begin
      m_run = 0; m_armed = 1'b0;
      m_width = 0; m_match = 0; m_pass = 0; m_err = 0;
    end else begin
      if (p) begin
        m_run++;
        if (m_armed && m_run == MAX_LEN + 1) begin
          m_timeout = 1;
          m_armed   = 1'b0;
          if (m_err < TALLY_SAT) m_err++;
        end
      end else begin
        if (m_armed && m_run > 0) begin
          m_valid = 1;
          m_width = m_run;
          m_match = (m_run == EXP_LEN) ? 1 : 0;
          if (m_match == 1) begin
            if (m_pass < TALLY_SAT) m_pass++;
          end else begin
            if (m_err < TALLY_SAT) m_err++;
          end
        end
        m_run   = 0;
        m_armed = 1'b1;
      end
      if (c) begin
        m_pass = 0;
        m_err  = 0;
      end
    end
  endtask

  task automatic cycle(input logic p, input logic c, input logic r, input string tag);
    pulse = p; clear = c; rst = r;
    @(posedge clk); #1;
    model_step(p, c, r);
    cmp_outs(tag, m_valid, m_width, m_match, m_timeout, m_pass, m_err);
    n_valid   += int'(valid);
    n_timeout += int'(timeout);
  endtask

  task automatic add(input logic p, input logic c, input int v, input int w, input int m,
                     input int t, input int pc, input int ec);
    vec_t e;
    e.p = p; e.c = c; e.v = v; e.w = w; e.m = m; e.t = t; e.pc = pc; e.ec = ec;
    vecs.push_back(e);
  endtask

  initial begin
    int t_at;

    // Table: 3 low cycles, 5-cycle pulse, 3-cycle pulse, 5-cycle pulse with
    // clear coinciding with its result update.
    //  p     c     v  w  m  t  pc ec
    add(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 1, 5, 1, 0, 1, 0);
    add(1'b0, 1'b0, 0, 5, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 0, 5, 1, 0, 1, 0);
    add(1'b0, 1'b0, 1, 3, 0, 0, 1, 1);
    add(1'b0, 1'b0, 0, 3, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 0, 3, 0, 0, 1, 1);
    add(1'b0, 1'b1, 1, 5, 1, 0, 0, 0);
    add(1'b0, 1'b0, 0, 5, 1, 0, 0, 0);

    // Reset state.
    cycle(1'b0, 1'b0, 1'b1, "rst0");
    cycle(1'b0, 1'b0, 1'b1, "rst1");

    // Vector table.
    foreach (vecs[i]) begin
      pulse = vecs[i].p; clear = vecs[i].c; rst = 1'b0;
      @(posedge clk); #1;
      model_step(vecs[i].p, vecs[i].c, 1'b0);
      cmp_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].w, vecs[i].m,
               vecs[i].t, vecs[i].pc, vecs[i].ec);
    end

    // Stuck-high line: timeout after the 21st high sample, no fall strobe.
    n_valid = 0; n_timeout = 0; t_at = 0;
    for (int i = 1; i <= 25; i++) begin
      cycle(1'b1, 1'b0, 1'b0, "t3_hi");
      if (timeout === 1'b1) t_at = i;
    end
    cycle(1'b0, 1'b0, 1'b0, "t3_lo");
    cycle(1'b0, 1'b0, 1'b0, "t3_lo");
    chk("t3_timeouts", n_timeout, 1);
    chk("t3_timeout_pos", t_at, 21);
    chk("t3_no_valid", n_valid, 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, "t3_p5");
    cycle(1'b0, 1'b0, 1'b0, "t3_p5_fall");
    chk("t3_p5_width", 32'(width), 5);
    chk("t3_p5_match", 32'(match), 1);

    // Reset while high, line stays high after release: no measurement.
    n_valid = 0; n_timeout = 0;
    cycle(1'b1, 1'b0, 1'b1, "t4_rst");
    cycle(1'b1, 1'b0, 1'b1, "t4_rst");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, "t4_hi");
    cycle(1'b0, 1'b0, 1'b0, "t4_lo");
    cycle(1'b0, 1'b0, 1'b0, "t4_lo");
    chk("t4_no_valid", n_valid, 0);
    chk("t4_no_timeout", n_timeout, 0);
    chk("t4_pass_zero", 32'(pass_count), 0);
    chk("t4_err_zero", 32'(err_count), 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, "t4_p5");
    cycle(1'b0, 1'b0, 1'b0, "t4_p5_fall");
    chk("t4_p5_valid", 32'(valid), 1);
    chk("t4_p5_width", 32'(width), 5);

    // Pulses 1, 1, 20 with one-cycle gaps.
    n_valid = 0; n_timeout = 0;
    cycle(1'b1, 1'b0, 1'b0, "t5_a");
    cycle(1'b0, 1'b0, 1'b0, "t5_gap");
    chk("t5_w1a", 32'(width), 1);
    cycle(1'b1, 1'b0, 1'b0, "t5_b");
    cycle(1'b0, 1'b0, 1'b0, "t5_gap");
    chk("t5_w1b", 32'(width), 1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, "t5_c");
    cycle(1'b0, 1'b0, 1'b0, "t5_gap");
    chk("t5_w20", 32'(width), 20);
    chk("t5_valids", n_valid, 3);
    chk("t5_no_timeout", n_timeout, 0);
    chk("t5_err3", 32'(err_count), 3);
    // Reset on the 3rd cycle of a 5-cycle pulse.
    n_valid = 0;
    cycle(1'b1, 1'b0, 1'b0, "t5_r");
    cycle(1'b1, 1'b0, 1'b0, "t5_r");
    cycle(1'b1, 1'b0, 1'b1, "t5_r_rst");
    cycle(1'b1, 1'b0, 1'b0, "t5_r");
    cycle(1'b1, 1'b0, 1'b0, "t5_r");
    cycle(1'b0, 1'b0, 1'b0, "t5_r_lo");
    chk("t5_r_no_valid", n_valid, 0);
    chk("t5_r_width0", 32'(width), 0);
    chk("t5_r_pass0", 32'(pass_count), 0);
    chk("t5_r_err0", 32'(err_count), 0);

    // Randomized segments against the reference model.
    for (int seg = 0; seg < 300; seg++) begin
      int lo;
      int hi;
      lo = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0:       hi = $urandom_range(18, 24);
        1:       hi = EXP_LEN;
        default: hi = $urandom_range(1, 8);
      endcase
      for (int i = 0; i < hi + lo; i++) begin
        cycle((i < hi) ? 1'b1 : 1'b0, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, "rnd");
      end
    end

    // Tally saturation on the 3-bit instance (expected length 1).
    cycle(1'b0, 1'b0, 1'b1, "sat_rst");
    cycle(1'b0, 1'b0, 1'b0, "sat_idle");
    for (int i = 0; i < 10; i++) begin
      pulse_s = 1'b1; cycle(1'b0, 1'b0, 1'b0, "sat_main");
      pulse_s = 1'b0; cycle(1'b0, 1'b0, 1'b0, "sat_main");
    end
    chk("sat_pass7", 32'(pass_s), 7);
    chk("sat_err0", 32'(err_s), 0);
    for (int i = 0; i < 10; i++) begin
      pulse_s = 1'b1; cycle(1'b0, 1'b0, 1'b0, "sat_main");
      cycle(1'b0, 1'b0, 1'b0, "sat_main");
      pulse_s = 1'b0; cycle(1'b0, 1'b0, 1'b0, "sat_main");
    end
    chk("sat_err7", 32'(err_s), 7);
    chk("sat_pass_held", 32'(pass_s), 7);
    chk("sat_width2", 32'(width_s), 2);
    clear_s = 1'b1; cycle(1'b0, 1'b0, 1'b0, "sat_main");
    clear_s = 1'b0;
    chk("sat_clear_pass", 32'(pass_s), 0);
    chk("sat_clear_err", 32'(err_s), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
